// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and multiply sequencer state type
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - EX-stage request/response bundle for the multiply sequencer
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALUCtrl_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  // EX stage side: issues requests, observes stall/done/result
  modport master (
    output start_i, ALUCtrl_i, flush_i, data1_i, data2_i,
    input  stall_o, done_o, result_o
  );

  // Sequencer side
  modport slave (
    input  start_i, ALUCtrl_i, flush_i, data1_i, data2_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - radix-2 shift-add datapath with early-termination detect
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             last_step_o,
  output logic [WIDTH-1:0] acc_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] psum_next;

  // The running partial sum lives in psum_q; acc_q is the architectural result
  // and is only written when an operation completes, so a flushed multiply
  // leaves the previous result visible.
  assign psum_next   = mplier_q[0] ? psum_q + mcand_q : psum_q;
  assign last_step_o = ((mplier_q >> 1) == '0) || (cnt_q == CW'(WIDTH - 1));
  assign acc_o       = acc_q;

  // Load on accept, shift/accumulate on each RUN step, commit on the last step
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    psum_d   = psum_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = data1_i;
      mplier_d = data2_i;
      psum_d   = '0;
      cnt_d    = '0;
      if (data2_i == '0) begin
        acc_d = '0;
      end
    end else if (step_i) begin
      psum_d   = psum_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_step_o) begin
        acc_d = psum_next;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      psum_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      psum_q   <= psum_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - iterative MUL sequencer with pipeline stall and done pulse
module mul_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_seq_ctrl_if.slave bus
);

  mul_state_t state_q, state_d;
  logic       accept;
  logic       load;
  logic       step;
  logic       last_step;

  assign accept = (state_q == IDLE) && bus.start_i && (bus.ALUCtrl_i == ALU_MUL) && !bus.flush_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls; flush overrides every transition
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    step        = 1'b0;
    bus.done_o  = 1'b0;
    bus.stall_o = accept || (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = (bus.data2_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = !bus.flush_i;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done_o = !bus.flush_i;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
    end
  end

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .step_i      (step),
    .data1_i     (bus.data1_i),
    .data2_i     (bus.data2_i),
    .last_step_o (last_step),
    .acc_o       (bus.result_o)
  );

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for the iterative multiply used by the EX stage when the ALU control decodes MUL (code 4'b1010). It accepts a multiply request from EX, runs a radix-2 shift-add loop with early termination, and holds the pipeline with a stall signal while the loop runs. It returns the low WIDTH bits of the product with a one-cycle done pulse. All other ALU operations bypass this block.

## Interface
- WIDTH, 32, operand and result width in bits

- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- start_i  input  1  EX stage holds a valid instruction
- ALUCtrl_i  input  4  ALU control code from ALU control; a request is a MUL only when this equals 4'b1010
- flush_i  input  1  synchronous abort of any in-flight multiply
- data1_i  input  WIDTH  multiplicand
- data2_i  input  WIDTH  multiplier
- stall_o  output  1  freeze PC, IF/ID and ID/EX
- done_o  output  1  one-cycle pulse; result_o valid
- result_o  output  WIDTH  product mod 2^WIDTH; holds until the next accept

## Operation
- States: IDLE, RUN, DONE.
- accept = (state==IDLE) && start_i && (ALUCtrl_i==4'b1010) && !flush_i.
- IDLE, on accept:
  - latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0.
  - If data2_i==0, go to DONE. Otherwise go to RUN.
- IDLE, no accept: stay in IDLE. Registers are unchanged.
- RUN, each cycle:
  - If mplier[0]==1, acc <= acc + mcand (mod 2^WIDTH).
  - mcand <= mcand<<1 (bits above WIDTH dropped). mplier <= mplier>>1. cnt <= cnt+1.
  - Go to DONE when (mplier>>1)==0 or cnt==WIDTH-1.
- DONE: done_o=1, then go to IDLE. start_i is ignored in DONE.
- flush_i in any state: next state is IDLE and no done_o is produced. flush_i has priority over accept. acc is not written by a flushed operation, so result_o keeps its previous value.
- Sign: the low WIDTH bits are identical for signed and unsigned operands, so no sign handling is needed.
- result_o is driven directly from the acc register.

## Timing
- Reset state: IDLE, acc=0, mcand=0, mplier=0, cnt=0. stall_o=0, done_o=0, result_o=0.
- Reset asserted mid-operation forces this state immediately, regardless of the clock.
- stall_o = accept || (state==RUN). It is combinational, so the stall is seen in the accept cycle itself.
- Let T be the accept cycle and k the index of the most-significant set bit of data2_i.
- Nonzero multiplier:
  - RUN occupies cycles T+1 .. T+k+1.
  - done_o is high in cycle T+k+2.
  - stall_o is high in cycles T .. T+k+1.
  - Worst case (k=31): done at T+33.
- Zero multiplier: done_o in cycle T+1; stall_o high in cycle T only.
- In the done cycle stall_o=0, so the pipeline advances and captures result_o. A start_i in the following IDLE cycle belongs to the next instruction.
- Back-to-back MULs: the minimum spacing between accepts is the done cycle plus one.

## Structure
- Shared package alu_pkg holds:
  - ALU control codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_MUL=4'b1010.
  - The mul_state_t enum (IDLE/RUN/DONE).
- One sub-module is natural: mul_shift_add_dp, holding the mcand/mplier/acc/cnt registers and the adder. It takes load/step controls from the FSM in mul_seq_ctrl and reports last_step back to it.

## Test plan
- data1=3, data2=5, MUL in cycle T → stall T..T+3; done_o in T+4 only; result_o=15.
- data1=32'hFFFFFFFF, data2=32'hFFFFFFFF → 32 RUN cycles; done_o in T+33; result_o=32'h00000001.
- data1=7, data2=0 → done_o in T+1; stall_o in T only; result_o=0.
- start_i=1 with ALUCtrl_i=4'b0010 → no stall, no done, result_o unchanged.
- data2=32'h80000000 with flush_i pulsed at T+5 → IDLE at T+6; no done_o; result_o keeps its prior value. A new MUL 2×2 then yields 4 at done.
- rst_i driven low at T+3 of a multiply (asynchronous, mid-cycle) → all outputs 0 immediately. start_i held high through the done cycle of 6×2 → exactly one done_o, result_o=12, no re-accept in DONE.
